flush_controller_nw: RTL and testbench
======================================

// Module: flush_controller_nw
// PURPOSE
// - N-wide, parametrised successor of the branch flush controller. Sits between decode and the branch-resolution path.
// - Per lane, captures the PC decoded immediately after each branch into an in-order next-PC buffer.
// - On each in-order branch resolution, compares the buffer head with the architecturally correct next PC and raises a flush on mismatch.
// - Adds a res_ready handshake, a stall-free delayed-compare FSM and correct +2/+4 fall-through in every path.
// PARAMETERS
// - PC_BITS        32  PC width
// - ROB_INDEX_BITS 3   ROB ticket width
// - MAX_BRANCH_IF  2   in-flight branch count; rat_id width is $clog2(MAX_BRANCH_IF)
// - FETCH_WIDTH    2   decode lanes per cycle (1..4)
// - DEPTH          8   next-PC buffer entries; power of two, >= 2*FETCH_WIDTH
// PORTS
// - clk             in   1                      clock
// - rst             in   1                      synchronous reset, active-high
// - dec_valid       in   FETCH_WIDTH            lane i holds a valid decoded instruction
// - dec_is_branch   in   FETCH_WIDTH            lane i is a branch/jump
// - dec_pc          in   FETCH_WIDTH*PC_BITS    lane i PC at bits [i*PC_BITS +: PC_BITS]
// - cap_ready       out  1                      buffer free entries >= FETCH_WIDTH; decode stalls when low
// - res_valid       in   1                      branch resolution, program order
// - res_ready       out  1                      resolution accepted when res_valid & res_ready
// - res_taken       in   1                      branch taken
// - res_target      in   PC_BITS                taken target
// - res_orig_pc     in   PC_BITS                branch PC
// - res_is_comp     in   1                      16-bit compressed branch
// - res_ticket      in   ROB_INDEX_BITS         ROB ticket of the branch
// - res_rat_id      in   $clog2(MAX_BRANCH_IF)  RAT checkpoint id
// - must_flush      out  1                      mispredict flush, single-cycle pulse
// - delayed_flush   out  1                      flush came from the WAIT path
// - correct_address out  PC_BITS                redirect PC
// - rob_ticket      out  ROB_INDEX_BITS         ticket of the flushing branch
// - rat_id          out  $clog2(MAX_BRANCH_IF)  checkpoint to restore
// - buf_count       out  $clog2(DEPTH)+1        buffer occupancy
// BEHAVIOUR
// - Reset (sync): buffer empty, pending=0, FSM=IDLE, counters 0. Output reset values:
//   - must_flush=0, delayed_flush=0, cap_ready=1, res_ready=1, buf_count=0
//   - correct_address, rob_ticket, rat_id = 0
// - Capture, per cycle, lanes scanned in ascending order:
//   - A valid lane is pushed iff the carried pending flag is set.
//   - After each valid lane, the carried flag becomes dec_is_branch[i].
//   - The pending register takes the final carried flag. Up to FETCH_WIDTH pushes per cycle, in lane order.
//   - No push is guaranteed while cap_ready=0. Decode must hold lanes invalid; pushes beyond free space are dropped.
// - Buffer storage is registered. A pushed entry becomes visible at the head the following cycle.
// - Correct next PC, identical in both paths:
//   - res_taken: res_target
//   - otherwise: res_orig_pc + (res_is_comp ? 2 : 4), computed modulo 2^PC_BITS
// - FSM IDLE, res_ready=1:
//   - Accept with buffer non-empty: compare head vs correct next PC, pop head.
//     On mismatch, must_flush=1 in the same cycle (combinational), with res_ticket and res_rat_id driven on the outputs.
//   - Accept with buffer empty: latch correct address, ticket and rat_id, go to WAIT. must_flush=0.
// - FSM WAIT, res_ready=0:
//   - When the buffer is non-empty, compare head vs the saved address and pop. Return to IDLE that cycle.
//   - On mismatch, must_flush=1, delayed_flush=1, and the saved ticket/rat_id/address drive the outputs.
// - Any must_flush has these next-cycle effects:
//   - Buffer cleared, pending=0, FSM=IDLE.
//   - Same-cycle pushes dropped, including the push that completes a WAIT compare.
// - Push and pop in the same cycle are both legal. Occupancy is updated by pushes minus pop.
// - Pointers wrap modulo DEPTH. Full and empty are distinguished by an extra pointer bit.
// - rst asserted mid-WAIT discards the saved state. No flush is emitted.
// CONFIGURATION
// - FLUSH_STATS_EN defined: adds three 32-bit wrapping counters, each cleared by rst:
//   - out stat_resolved: accepted resolutions
//   - out stat_flushes: must_flush pulses
//   - out stat_delayed: delayed_flush pulses
// - FLUSH_STATS_EN undefined: these ports and counters do not exist. All other behaviour is identical.
// TESTING
// - Lane0 branch at 0x100 plus lane1 0x104 -> 0x104 pushed. Resolve not-taken, orig 0x100 -> pop, must_flush=0.
// - Buffer head 0x104; resolve taken, target 0x200, ticket 5 -> must_flush=1, correct_address=0x200, rob_ticket=5. Next cycle buf_count=0.
// - Resolve with empty buffer, compressed not-taken, orig 0x300 -> WAIT, res_ready=0.
//   - Then push 0x308 -> next cycle must_flush=1, delayed_flush=1, correct_address=0x302.
// - FETCH_WIDTH=2, branch in lane1 (0x40) -> pending=1. Next cycle lane0 0x44 is pushed, with no flush on an untaken resolve.
// - Fill to DEPTH-1 -> cap_ready=0. Simultaneous push/pop at wrap keeps buf_count constant and FIFO order intact.
// - With FLUSH_STATS_EN: 3 resolves, 1 mispredict -> stat_resolved=3, stat_flushes=1.

Source files
------------

// File: rtl/flush_controller_nw.sv
// Purpose : N-wide branch flush controller. It keeps the PC decoded after each branch in an
//           in-order buffer and checks it against every resolved branch. A mismatch raises a flush.
// Latency : A compare in IDLE flushes combinationally in the accept cycle. A compare in WAIT
//           flushes in the first cycle the buffer head is valid.
// Backpr. : cap_ready falls when fewer than FETCH_WIDTH entries are free. res_ready is low in WAIT.
// Ports   : clk/rst (sync, active-high); dec_* decode lanes; cap_ready; res_* resolution handshake;
//           must_flush/delayed_flush/correct_address/rob_ticket/rat_id redirect; buf_count occupancy.
// Option  : FLUSH_STATS_EN adds stat_resolved/stat_flushes/stat_delayed 32-bit wrapping counters.
module flush_controller_nw #(
   parameter int PC_BITS        = 32,
   parameter int ROB_INDEX_BITS = 3,
   parameter int MAX_BRANCH_IF  = 2,
   parameter int FETCH_WIDTH    = 2,
   parameter int DEPTH          = 8
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [FETCH_WIDTH-1:0]           dec_valid,
   input  logic [FETCH_WIDTH-1:0]           dec_is_branch,
   input  logic [FETCH_WIDTH*PC_BITS-1:0]   dec_pc,
   output logic                             cap_ready,
   input  logic                             res_valid,
   output logic                             res_ready,
   input  logic                             res_taken,
   input  logic [PC_BITS-1:0]               res_target,
   input  logic [PC_BITS-1:0]               res_orig_pc,
   input  logic                             res_is_comp,
   input  logic [ROB_INDEX_BITS-1:0]        res_ticket,
   input  logic [$clog2(MAX_BRANCH_IF)-1:0] res_rat_id,
   output logic                             must_flush,
   output logic                             delayed_flush,
   output logic [PC_BITS-1:0]               correct_address,
   output logic [ROB_INDEX_BITS-1:0]        rob_ticket,
   output logic [$clog2(MAX_BRANCH_IF)-1:0] rat_id,
   output logic [$clog2(DEPTH):0]           buf_count
`ifdef FLUSH_STATS_EN
   ,
   output logic [31:0]                      stat_resolved,
   output logic [31:0]                      stat_flushes,
   output logic [31:0]                      stat_delayed
`endif
);
   localparam int AW = $clog2(DEPTH);
   localparam int RW = $clog2(MAX_BRANCH_IF);
   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_WAIT = 1'b1;

   logic [PC_BITS-1:0]        mem_q [DEPTH];
   logic [PC_BITS-1:0]        mem_d [DEPTH];
   logic [AW:0]               wr_q, wr_d, rd_q, rd_d;
   logic                      pending_q, pending_d;
   logic [0:0]                state_q, state_d;
   logic [PC_BITS-1:0]        sv_addr_q, sv_addr_d;
   logic [ROB_INDEX_BITS-1:0] sv_ticket_q, sv_ticket_d;
   logic [RW-1:0]             sv_rat_q, sv_rat_d;

   logic [AW:0]               count;
   logic [PC_BITS-1:0]        head;
   logic [PC_BITS-1:0]        next_pc;
   logic                      pop;
   logic                      carried;
   int                        n_push;
   logic [AW-1:0]             widx;

   // The extra pointer bit makes wr - rd equal DEPTH (not 0) when the buffer is full.
   assign count     = wr_q - rd_q;
   assign buf_count = count;
   assign head      = mem_q[rd_q[AW-1:0]];
   assign cap_ready = (DEPTH - int'(count)) >= FETCH_WIDTH;
   assign next_pc   = res_taken ? res_target
                                : res_orig_pc + (res_is_comp ? PC_BITS'(2) : PC_BITS'(4));

   always_comb begin
      mem_d           = mem_q;
      wr_d            = wr_q;
      rd_d            = rd_q;
      pending_d       = pending_q;
      state_d         = state_q;
      sv_addr_d       = sv_addr_q;
      sv_ticket_d     = sv_ticket_q;
      sv_rat_d        = sv_rat_q;
      pop             = 1'b0;
      must_flush      = 1'b0;
      delayed_flush   = 1'b0;
      correct_address = '0;
      rob_ticket      = '0;
      rat_id          = '0;
      res_ready       = (state_q == ST_IDLE);
      carried         = pending_q;
      n_push          = 0;
      widx            = '0;

      // Resolution side
      if (state_q == ST_IDLE) begin
         if (res_valid) begin
            if (count != '0) begin
               pop = 1'b1;
               if (head != next_pc) begin
                  must_flush      = 1'b1;
                  correct_address = next_pc;
                  rob_ticket      = res_ticket;
                  rat_id          = res_rat_id;
               end
            end else begin
               // The successor PC is not decoded yet: hold the resolution until it arrives.
               state_d     = ST_WAIT;
               sv_addr_d   = next_pc;
               sv_ticket_d = res_ticket;
               sv_rat_d    = res_rat_id;
            end
         end
      end else if (count != '0) begin
         pop     = 1'b1;
         state_d = ST_IDLE;
         if (head != sv_addr_q) begin
            must_flush      = 1'b1;
            delayed_flush   = 1'b1;
            correct_address = sv_addr_q;
            rob_ticket      = sv_ticket_q;
            rat_id          = sv_rat_q;
         end
      end

      // Capture side. A lane is pushed when the previous valid lane (possibly from an
      // earlier cycle, via pending) was a branch. A flush drops all of this cycle's pushes.
      for (int i = 0; i < FETCH_WIDTH; i++) begin
         if (dec_valid[i]) begin
            if (carried && !must_flush && (int'(count) + n_push < DEPTH)) begin
               widx        = wr_q[AW-1:0] + AW'(n_push);
               mem_d[widx] = dec_pc[i*PC_BITS +: PC_BITS];
               n_push      = n_push + 1;
            end
            carried = dec_is_branch[i];
         end
      end

      if (must_flush) begin
         wr_d      = '0;
         rd_d      = '0;
         pending_d = 1'b0;
         state_d   = ST_IDLE;
      end else begin
         wr_d      = wr_q + (AW+1)'(n_push);
         rd_d      = rd_q + {{AW{1'b0}}, pop};
         pending_d = carried;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_q        <= '0;
         rd_q        <= '0;
         pending_q   <= 1'b0;
         state_q     <= ST_IDLE;
         sv_addr_q   <= '0;
         sv_ticket_q <= '0;
         sv_rat_q    <= '0;
      end else begin
         mem_q       <= mem_d;
         wr_q        <= wr_d;
         rd_q        <= rd_d;
         pending_q   <= pending_d;
         state_q     <= state_d;
         sv_addr_q   <= sv_addr_d;
         sv_ticket_q <= sv_ticket_d;
         sv_rat_q    <= sv_rat_d;
      end
   end

`ifdef FLUSH_STATS_EN
   logic [31:0] st_res_q, st_res_d, st_fl_q, st_fl_d, st_dl_q, st_dl_d;

   always_comb begin
      st_res_d = st_res_q + {31'd0, (res_valid & res_ready)};
      st_fl_d  = st_fl_q  + {31'd0, must_flush};
      st_dl_d  = st_dl_q  + {31'd0, delayed_flush};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         st_res_q <= '0;
         st_fl_q  <= '0;
         st_dl_q  <= '0;
      end else begin
         st_res_q <= st_res_d;
         st_fl_q  <= st_fl_d;
         st_dl_q  <= st_dl_d;
      end
   end

   assign stat_resolved = st_res_q;
   assign stat_flushes  = st_fl_q;
   assign stat_delayed  = st_dl_q;
`endif
endmodule

// File: tb/tb_flush_controller_nw.sv
module tb_flush_controller_nw;
   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  dec_valid, dec_is_branch;
   logic [63:0] dec_pc;
   logic        cap_ready, res_valid, res_ready, res_taken, res_is_comp;
   logic [31:0] res_target, res_orig_pc;
   logic [2:0]  res_ticket;
   logic [0:0]  res_rat_id;
   logic        must_flush, delayed_flush;
   logic [31:0] correct_address;
   logic [2:0]  rob_ticket;
   logic [0:0]  rat_id;
   logic [3:0]  buf_count;
`ifdef FLUSH_STATS_EN
   logic [31:0] stat_resolved, stat_flushes, stat_delayed;
`endif

   flush_controller_nw dut (
      .clk(clk), .rst(rst),
      .dec_valid(dec_valid), .dec_is_branch(dec_is_branch), .dec_pc(dec_pc),
      .cap_ready(cap_ready),
      .res_valid(res_valid), .res_ready(res_ready), .res_taken(res_taken),
      .res_target(res_target), .res_orig_pc(res_orig_pc), .res_is_comp(res_is_comp),
      .res_ticket(res_ticket), .res_rat_id(res_rat_id),
      .must_flush(must_flush), .delayed_flush(delayed_flush),
      .correct_address(correct_address), .rob_ticket(rob_ticket), .rat_id(rat_id),
      .buf_count(buf_count)
`ifdef FLUSH_STATS_EN
      , .stat_resolved(stat_resolved), .stat_flushes(stat_flushes), .stat_delayed(stat_delayed)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic [2:0]  ticket;
      logic [0:0]  rat;
      logic        delayed;
   } flush_t;

   flush_t      exp_q[$];
   logic [31:0] model_q[$];
   int          checks = 0;
   int          errors = 0;
   int          exp_resolved = 0;
   int          exp_flushes  = 0;
   int          exp_delayed  = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: every flush pulse is matched against the oldest expected flush.
   always @(negedge clk) begin
      if (!rst && must_flush) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_flush: got addr 0x%0h expected no flush", correct_address);
         end else begin
            flush_t e;
            e = exp_q.pop_front();
            chk("flush_addr", 64'(correct_address), 64'(e.addr));
            chk("flush_ticket", 64'(rob_ticket), 64'(e.ticket));
            chk("flush_rat", 64'(rat_id), 64'(e.rat));
            chk("flush_delayed", 64'(delayed_flush), 64'(e.delayed));
         end
      end
   end

   task automatic clr();
      dec_valid = '0; dec_is_branch = '0; dec_pc = '0;
      res_valid = 0; res_taken = 0; res_is_comp = 0;
      res_target = '0; res_orig_pc = '0; res_ticket = '0; res_rat_id = '0;
   endtask

   task automatic step();
      @(posedge clk);
      #1 clr();
      #1;
   endtask

   task automatic lanes(input logic [1:0] v, input logic [1:0] br,
                        input logic [31:0] pc0, input logic [31:0] pc1);
      dec_valid = v; dec_is_branch = br; dec_pc = {pc1, pc0};
   endtask

   task automatic resolve(input logic tk, input logic [31:0] tgt, input logic [31:0] orig,
                          input logic comp, input logic [2:0] tkt, input logic [0:0] rat);
      res_valid = 1; res_taken = tk; res_target = tgt; res_orig_pc = orig;
      res_is_comp = comp; res_ticket = tkt; res_rat_id = rat;
      exp_resolved++;
   endtask

   // Resolve so the correct next PC equals pc, using one of three encodings.
   task automatic resolve_ok(input logic [31:0] pc, input int mode);
      case (mode % 3)
         0: resolve(1'b0, 32'h0, pc - 32'd4, 1'b0, 3'd1, 1'b0);
         1: resolve(1'b1, pc, 32'h9000, 1'b0, 3'd2, 1'b1);
         default: resolve(1'b0, 32'h0, pc - 32'd2, 1'b1, 3'd3, 1'b0);
      endcase
   endtask

   task automatic expect_flush(input logic [31:0] a, input logic [2:0] t,
                               input logic [0:0] r, input logic d);
      flush_t e;
      e.addr = a; e.ticket = t; e.rat = r; e.delayed = d;
      exp_q.push_back(e);
      exp_flushes++;
      if (d) exp_delayed++;
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin
      clr();
      rst = 1;
      step(); step();
      rst = 0;
      exp_resolved = 0; exp_flushes = 0; exp_delayed = 0;
      #1;
      chk("rst_must_flush", 64'(must_flush), 64'd0);
      chk("rst_delayed", 64'(delayed_flush), 64'd0);
      chk("rst_cap_ready", 64'(cap_ready), 64'd1);
      chk("rst_res_ready", 64'(res_ready), 64'd1);
      chk("rst_buf_count", 64'(buf_count), 64'd0);
      chk("rst_addr", 64'(correct_address), 64'd0);
      chk("rst_ticket", 64'(rob_ticket), 64'd0);
      chk("rst_rat", 64'(rat_id), 64'd0);

      // Branch at 0x100 in lane0: lane1 0x104 is captured, untaken resolve matches.
      lanes(2'b11, 2'b01, 32'h100, 32'h104); step();
      chk("s1_count", 64'(buf_count), 64'd1);
      resolve(1'b0, 32'h0, 32'h100, 1'b0, 3'd0, 1'b0); step();
      chk("s1_pop_count", 64'(buf_count), 64'd0);

      // Taken mispredict. Same-cycle pushes and the pending flag must be discarded.
      lanes(2'b11, 2'b01, 32'h100, 32'h104); step();
      resolve(1'b1, 32'h200, 32'h100, 1'b0, 3'd5, 1'b1);
      lanes(2'b11, 2'b11, 32'h500, 32'h504);
      expect_flush(32'h200, 3'd5, 1'b1, 1'b0);
      step();
      chk("s2_cleared", 64'(buf_count), 64'd0);
      lanes(2'b01, 2'b00, 32'h600, 32'h0); step();
      chk("s2_pending_cleared", 64'(buf_count), 64'd0);

      // Empty-buffer resolve goes to WAIT, and the late 0x308 mismatches 0x302.
      resolve(1'b0, 32'h0, 32'h300, 1'b1, 3'd3, 1'b0); step();
      chk("s3_wait_res_ready", 64'(res_ready), 64'd0);
      lanes(2'b11, 2'b01, 32'h304, 32'h308);
      expect_flush(32'h302, 3'd3, 1'b0, 1'b1);
      step();
      chk("s3_count_head", 64'(buf_count), 64'd1);
      step();
      chk("s3_after_count", 64'(buf_count), 64'd0);
      chk("s3_idle_res_ready", 64'(res_ready), 64'd1);
      chk("s3_flushq_drained", 64'(exp_q.size()), 64'd0);

      // Reset during WAIT drops the saved resolution.
      resolve(1'b0, 32'h0, 32'h400, 1'b0, 3'd4, 1'b0); step();
      chk("s4_wait", 64'(res_ready), 64'd0);
      rst = 1; step(); rst = 0;
      exp_resolved = 0; exp_flushes = 0; exp_delayed = 0;
      chk("s4_rst_res_ready", 64'(res_ready), 64'd1);
      lanes(2'b11, 2'b01, 32'h700, 32'h704); step();
      chk("s4_count", 64'(buf_count), 64'd1);
      resolve(1'b0, 32'h0, 32'h700, 1'b0, 3'd1, 1'b0); step();
      chk("s4_pop", 64'(buf_count), 64'd0);

      // Branch in lane1 carries across to the next cycle's lane0.
      lanes(2'b10, 2'b10, 32'h0, 32'h40); step();
      chk("s5_no_push", 64'(buf_count), 64'd0);
      lanes(2'b01, 2'b00, 32'h44, 32'h0); step();
      chk("s5_carry_push", 64'(buf_count), 64'd1);
      resolve(1'b0, 32'h0, 32'h40, 1'b0, 3'd2, 1'b0); step();
      chk("s5_pop", 64'(buf_count), 64'd0);

      // Fill to 7 entries (1,3,5,7), then pop 3, then push+pop across the wrap.
      lanes(2'b11, 2'b11, 32'h1000, 32'h1004); model_q.push_back(32'h1004); step();
      chk("fill_count1", 64'(buf_count), 64'd1);
      chk("fill_ready1", 64'(cap_ready), 64'd1);
      for (int k = 0; k < 3; k++) begin
         logic [31:0] p0;
         p0 = 32'h1008 + 32'(k * 8);
         lanes(2'b11, 2'b11, p0, p0 + 32'd4);
         model_q.push_back(p0); model_q.push_back(p0 + 32'd4);
         step();
      end
      chk("fill_count7", 64'(buf_count), 64'd7);
      chk("fill_ready_low", 64'(cap_ready), 64'd0);
      for (int k = 0; k < 3; k++) begin
         resolve_ok(model_q.pop_front(), k);
         step();
      end
      chk("drain_count4", 64'(buf_count), 64'd4);
      chk("drain_ready", 64'(cap_ready), 64'd1);
      for (int k = 0; k < 4; k++) begin
         logic [31:0] p;
         p = 32'h2000 + 32'(k * 4);
         resolve_ok(model_q.pop_front(), k + 1);
         lanes(2'b01, 2'b01, p, 32'h0);
         model_q.push_back(p);
         step();
         chk("wrap_count", 64'(buf_count), 64'd4);
      end
      for (int k = 0; k < 4; k++) begin
         resolve_ok(model_q.pop_front(), k);
         step();
      end
      chk("final_count", 64'(buf_count), 64'd0);

      // One final mismatch with a non-empty buffer.
      lanes(2'b11, 2'b01, 32'h800, 32'h804); step();
      resolve(1'b0, 32'h0, 32'h800, 1'b1, 3'd6, 1'b1);
      expect_flush(32'h802, 3'd6, 1'b1, 1'b0);
      step();
      chk("last_cleared", 64'(buf_count), 64'd0);
      step();
      chk("flushq_drained", 64'(exp_q.size()), 64'd0);
`ifdef FLUSH_STATS_EN
      chk("stat_resolved", 64'(stat_resolved), 64'(exp_resolved));
      chk("stat_flushes", 64'(stat_flushes), 64'(exp_flushes));
      chk("stat_delayed", 64'(stat_delayed), 64'(exp_delayed));
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
